// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU constants and the square-root result entry type
package fpu_pkg;

    localparam int FP_W      = 32;
    localparam int FSQRT_LAT = 2;
    // Widest destination tag a result entry can carry; narrower tags are zero-extended.
    localparam int TAG_MAX_W = 8;

    typedef struct packed {
        logic [FP_W-1:0]      y;
        logic                 exc;
        logic [TAG_MAX_W-1:0] tag;
    } fpu_res_t;

endpackage

// File: rtl/fpu_result_fifo.sv
// rtl/fpu_result_fifo.sv - power-of-two result queue with push/pop and occupancy count
module fpu_result_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/fpu_sqrt_dispatch.sv
// rtl/fpu_sqrt_dispatch.sv - credit-based dispatcher for an external fixed-latency fsqrt unit
module fpu_sqrt_dispatch
    import fpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 5,
    parameter int LAT   = FSQRT_LAT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [FP_W-1:0]  req_x,
    input  logic [TAG_W-1:0] req_tag,
    output logic [FP_W-1:0]  sq_x,
    output logic             sq_enable,
    input  logic [FP_W-1:0]  sq_y,
    input  logic             sq_enable_out,
    input  logic             sq_exception,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [FP_W-1:0]  res_y,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_exc,
    output logic             exc_sticky,
    input  logic             exc_clear,
    output logic             proto_err
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SUM_W = $clog2(DEPTH + LAT + 1);
    localparam int BLK_W = $clog2(LAT + 1);

    logic [LAT-1:0]   valid_q, valid_d;
    logic [TAG_W-1:0] tag_q [LAT];
    logic [TAG_W-1:0] tag_d [LAT];
    logic             exc_sticky_q, exc_sticky_d;
    logic             proto_err_q, proto_err_d;
    logic [BLK_W-1:0] blank_q, blank_d;

    logic             accept, pipe_v, pop;
    logic [TAG_W-1:0] pipe_tag;
    logic [SUM_W-1:0] inflight, used;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full, fifo_empty;
    fpu_res_t         push_entry, head;
    logic             unused_head_tag;

    assign pipe_v   = valid_q[LAT-1];
    assign pipe_tag = tag_q[LAT-1];

    // Credits cover both queued results and operations still inside fsqrt,
    // so a push can never find the queue full. A same-cycle pop is not credited.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) inflight = inflight + SUM_W'(valid_q[i]);
        used = SUM_W'(fifo_count) + inflight;
    end

    assign req_ready = !rst && !fifo_full && (used < SUM_W'(DEPTH));
    assign accept    = req_valid && req_ready;
    assign sq_enable = accept;
    assign sq_x      = rst ? '0 : req_x;

    always_comb begin
        valid_d[0] = accept;
        tag_d[0]   = req_tag;
        for (int i = 1; i < LAT; i++) begin
            valid_d[i] = valid_q[i-1];
            tag_d[i]   = tag_q[i-1];
        end
    end

    // fsqrt is not reset, so its enable_out is untrustworthy for LAT edges after reset.
    always_comb begin
        exc_sticky_d = exc_sticky_q;
        proto_err_d  = proto_err_q;
        blank_d      = blank_q;
        if (exc_clear)                exc_sticky_d = 1'b0;
        if (pipe_v && sq_exception)   exc_sticky_d = 1'b1;
        if (blank_q != '0)            blank_d = blank_q - BLK_W'(1);
        else if (sq_enable_out != pipe_v) proto_err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q      <= '0;
            exc_sticky_q <= 1'b0;
            proto_err_q  <= 1'b0;
            blank_q      <= BLK_W'(LAT);
        end else begin
            valid_q      <= valid_d;
            exc_sticky_q <= exc_sticky_d;
            proto_err_q  <= proto_err_d;
            blank_q      <= blank_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_q <= tag_d;
    end

    assign push_entry = '{y: sq_y, exc: sq_exception, tag: TAG_MAX_W'(pipe_tag)};
    assign pop        = res_valid && res_ready;

    fpu_result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fpu_res_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (pipe_v),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign unused_head_tag = ^head.tag;

    assign res_valid  = !fifo_empty;
    assign res_y      = res_valid ? head.y : '0;
    assign res_tag    = res_valid ? head.tag[TAG_W-1:0] : '0;
    assign res_exc    = res_valid && head.exc;
    assign exc_sticky = exc_sticky_q;
    assign proto_err  = proto_err_q;

endmodule

// File: tb/tb_fpu_sqrt_dispatch.sv
// tb/tb_fpu_sqrt_dispatch.sv - scoreboard bench for fpu_sqrt_dispatch with a 2-stage fsqrt model
module tb_fpu_sqrt_dispatch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_x = '0;
    logic [4:0]  req_tag = '0;
    logic [31:0] sq_x;
    logic        sq_enable;
    logic [31:0] sq_y;
    logic        sq_enable_out;
    logic        sq_exception;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_y;
    logic [4:0]  res_tag;
    logic        res_exc;
    logic        exc_sticky;
    logic        exc_clear = 1'b0;
    logic        proto_err;

    fpu_sqrt_dispatch dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_x         (req_x),
        .req_tag       (req_tag),
        .sq_x          (sq_x),
        .sq_enable     (sq_enable),
        .sq_y          (sq_y),
        .sq_enable_out (sq_enable_out),
        .sq_exception  (sq_exception),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_y         (res_y),
        .res_tag       (res_tag),
        .res_exc       (res_exc),
        .exc_sticky    (exc_sticky),
        .exc_clear     (exc_clear),
        .proto_err     (proto_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    bit lat_chk = 1'b0;
    logic force_eo = 1'b0;

    typedef struct {
        logic [31:0] y;
        logic        exc;
        logic [4:0]  tag;
        int          cyc;
        bit          lat;
    } exp_t;
    exp_t sb[$];

    logic [31:0] tab [8] = '{32'h40800000, 32'h3F800000, 32'h41800000, 32'h41100000,
                             32'h3E800000, 32'h00000000, 32'hBF800000, 32'h40400000};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [32:0] fsqrt_ref(input logic [31:0] x);
        if (x[31] && x[30:0] != 31'd0) return {1'b1, 32'hFFC00000};
        case (x)
            32'h40800000: return {1'b0, 32'h40000000};
            32'h3F800000: return {1'b0, 32'h3F800000};
            32'h41800000: return {1'b0, 32'h40800000};
            32'h41100000: return {1'b0, 32'h40400000};
            32'h3E800000: return {1'b0, 32'h3F000000};
            32'h00000000: return {1'b0, 32'h00000000};
            default:      return {1'b0, x ^ 32'h12345678};
        endcase
    endfunction

    // Stand-in fsqrt: fixed two-edge latency, no reset.
    logic        m_en [2] = '{1'b0, 1'b0};
    logic [32:0] m_r  [2] = '{33'd0, 33'd0};
    always @(posedge clk) begin
        m_en[1] <= m_en[0];
        m_en[0] <= sq_enable;
        m_r[1]  <= m_r[0];
        m_r[0]  <= fsqrt_ref(sq_x);
    end
    assign sq_y          = m_r[1][31:0];
    assign sq_exception  = m_r[1][32];
    assign sq_enable_out = m_en[1] | force_eo;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", 32'(res_tag), 32'hFFFFFFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("res_y", res_y, e.y);
                    check("res_tag", 32'(res_tag), 32'(e.tag));
                    check("res_exc", 32'(res_exc), 32'(e.exc));
                    if (e.lat) check("latency", 32'(cyc - e.cyc), 32'd3);
                end
            end
            if (req_valid && req_ready) begin
                logic [32:0] r;
                r = fsqrt_ref(req_x);
                sb.push_back('{y: r[31:0], exc: r[32], tag: req_tag, cyc: cyc, lat: lat_chk});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] x, input logic [4:0] t);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_x     = x;
        req_tag   = t;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("send_timeout", 32'(req_ready), 32'd1);
        tick();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || res_valid) && n < 40) begin
            tick();
            n++;
        end
        if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int acc;
        int w;
        int seen;

        req_valid = 1'b1;
        req_x     = 32'h40800000;
        repeat (3) tick();
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_sq_enable", 32'(sq_enable), 32'd0);
        check("rst_sq_x", sq_x, 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_exc_sticky", 32'(exc_sticky), 32'd0);
        check("rst_proto_err", 32'(proto_err), 32'd0);
        tick();
        req_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(req_ready), 32'd1);
        tick();

        // Scenario 1: single request, exact latency
        res_ready = 1'b1;
        lat_chk   = 1'b1;
        req_valid = 1'b1;
        req_x     = 32'h40800000;
        req_tag   = 5'd3;
        #1;
        check("s1_sq_x", sq_x, 32'h40800000);
        check("s1_sq_enable", 32'(sq_enable), 32'd1);
        send(32'h40800000, 5'd3);
        req_valid = 1'b0;
        wait_idle();
        @(negedge clk);
        check("idle_res_y", res_y, 32'd0);
        check("idle_res_tag", 32'(res_tag), 32'd0);
        check("idle_res_exc", 32'(res_exc), 32'd0);
        tick();

        // Scenario 2: exception, sticky set/clear priority
        send(32'hBF800000, 5'd1);
        req_valid = 1'b0;
        wait_idle();
        @(negedge clk);
        check("s2_sticky_set", 32'(exc_sticky), 32'd1);
        tick();
        exc_clear = 1'b1;
        tick();
        exc_clear = 1'b0;
        @(negedge clk);
        check("s2_sticky_clr", 32'(exc_sticky), 32'd0);
        tick();
        send(32'hBF800000, 5'd2);
        req_valid = 1'b0;
        tick();
        exc_clear = 1'b1;
        tick();
        exc_clear = 1'b0;
        @(negedge clk);
        check("s2_set_beats_clr", 32'(exc_sticky), 32'd1);
        wait_idle();

        // Scenario 3: backpressure and credit return
        lat_chk   = 1'b0;
        res_ready = 1'b0;
        acc       = 0;
        req_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req_x   = tab[i];
            req_tag = 5'(10 + i);
            @(negedge clk);
            if (req_ready) acc++;
            tick();
        end
        check("s3_accepts", 32'(acc), 32'd4);
        @(negedge clk);
        check("s3_ready_low", 32'(req_ready), 32'd0);
        tick();
        req_valid = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        @(negedge clk);
        check("s3_ready_after_pop", 32'(req_ready), 32'd1);
        tick();
        res_ready = 1'b1;
        wait_idle();

        // Scenario 4: back-to-back, in-order, full throughput
        lat_chk = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++) send(tab[i], 5'(i));
                req_valid = 1'b0;
            end
            begin
                w = 0;
                @(negedge clk);
                while (!res_valid && w < 20) begin
                    @(negedge clk);
                    w++;
                end
                for (int i = 0; i < 8; i++) begin
                    check("s4_run", 32'(res_valid), 32'd1);
                    check("s4_order", 32'(res_tag), 32'(i));
                    @(negedge clk);
                end
            end
        join
        wait_idle();
        @(negedge clk);
        check("s4_no_proto_err", 32'(proto_err), 32'd0);
        tick();

        // Scenario 5: reset drops in-flight operations
        send(32'h3F800000, 5'd20);
        send(32'h41800000, 5'd21);
        req_valid = 1'b0;
        rst = 1'b1;
        sb.delete();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("s5_ready", 32'(req_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (res_valid) seen++;
            @(negedge clk);
        end
        check("s5_no_results", 32'(seen), 32'd0);
        check("s5_proto_err", 32'(proto_err), 32'd0);
        tick();

        // Scenario 6: spurious enable_out
        force_eo = 1'b1;
        tick();
        force_eo = 1'b0;
        @(negedge clk);
        check("s6_proto_err", 32'(proto_err), 32'd1);
        check("s6_res_valid", 32'(res_valid), 32'd0);
        check("s6_ready", 32'(req_ready), 32'd1);
        tick();
        tick();
        @(negedge clk);
        check("s6_sticky", 32'(proto_err), 32'd1);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fpu_sqrt_dispatch.md
FPU_SQRT_DISPATCH -- requirements
Module: fpu_sqrt_dispatch

Interface
REQ-001 The parameter DEPTH SHALL default to 4 and set the number of result-queue entries (power of two, at least 2).
REQ-002 The parameter TAG_W SHALL default to 5 and set the width of the destination-register tag.
REQ-003 The parameter LAT SHALL default to 2 and set the fixed fsqrt pipeline latency in clock edges.
REQ-004 clk  input  1  sole clock; every register SHALL update on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 req_valid  input  1  a request is presented.
REQ-007 req_ready  output  1  the request is accepted this cycle when it and req_valid are both high.
REQ-008 req_x  input  32  IEEE-754 single-precision operand.
REQ-009 req_tag  input  TAG_W  destination tag travelling with the operand.
REQ-010 sq_x  output  32  operand sent to the fsqrt x input; equals req_x combinationally.
REQ-011 sq_enable  output  1  drives fsqrt enable_in; equals req_valid AND req_ready.
REQ-012 sq_y  input  32  fsqrt y output.
REQ-013 sq_enable_out  input  1  fsqrt enable_out.
REQ-014 sq_exception  input  1  fsqrt exception output.
REQ-015 res_valid  output  1  the queue head holds a result.
REQ-016 res_ready  input  1  the consumer takes the head this cycle.
REQ-017 res_y, res_tag, res_exc  output  32 / TAG_W / 1  head result, its tag and its exception bit.
REQ-018 exc_sticky  output  1  sticky exception flag.
REQ-019 exc_clear  input  1  clears exc_sticky.
REQ-020 proto_err  output  1  sticky flag, set on a latency mismatch.

Function
REQ-021 On each accept, the block SHALL shift {1, req_tag} into a LAT-deep valid/tag pipe; a non-accept cycle SHALL shift in {0, x}.
REQ-022 When the pipe output valid bit is 1, the block SHALL push {sq_y, sq_exception, pipe tag} into the queue at that edge, which is accept edge + LAT.
REQ-023 A pushed entry SHALL assert res_valid in the cycle after the push; accept-to-res_valid latency is therefore LAT+1 = 3 cycles, with no bypass path.
REQ-024 The credit rule SHALL be: req_ready = (queue count + in-flight count) < DEPTH, where in-flight count is the number of set pipe valid bits; a pop in the same cycle SHALL NOT be credited.
REQ-025 Results SHALL leave the queue in accept order; sustained throughput SHALL be 1 request per cycle while res_ready is held high.
REQ-026 A simultaneous push and pop SHALL leave count unchanged; a push into a full queue cannot occur because of REQ-024.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH; count SHALL be DEPTH+1 values wide.
REQ-028 When res_valid is 0, res_y, res_tag and res_exc SHALL be 0.
REQ-029 exc_sticky SHALL set when an entry with exception=1 is pushed; exc_clear SHALL clear it; a set and a clear in the same cycle SHALL leave it set.
REQ-030 proto_err SHALL set when sq_enable_out differs from the pipe output valid bit, and SHALL clear only on reset; data SHALL be taken from the pipe valid bit, never from sq_enable_out.

Reset
REQ-031 rst SHALL immediately clear the pipe valid bits, the pointers, count, exc_sticky and proto_err.
REQ-032 While rst is high, all outputs SHALL be 0, including req_ready.
REQ-033 After rst falls, req_ready SHALL be 1 in the first cycle.
REQ-034 Results of operations that were in flight when rst was asserted SHALL be dropped.
REQ-035 For LAT cycles after rst falls, proto_err SHALL ignore sq_enable_out, because fsqrt has no reset.

Structure
REQ-036 A shared package fpu_pkg SHALL hold the constants FSQRT_LAT=2, FP_W=32 and the result-entry struct {y, exc, tag}.
REQ-037 The queue SHALL be a single sub-module fpu_result_fifo (parameters DEPTH, WIDTH) with push, pop, full, empty and count ports.
REQ-038 fsqrt SHALL be instantiated outside this block, by its parent.

Verification
REQ-039 Scenario 1: req_x=0x40800000, tag=3, res_ready=1 -> res_valid exactly 3 cycles later with res_y=0x40000000, res_tag=3, res_exc=0.
REQ-040 Scenario 2: req_x=0xBF800000 -> res_y=0xFFC00000, res_exc=1, exc_sticky=1; then exc_clear in the same cycle as a new exception -> exc_sticky stays 1.
REQ-041 Scenario 3: res_ready=0 with continuous requests -> exactly 4 accepts, then req_ready=0; one pop -> req_ready=1 in the following cycle.
REQ-042 Scenario 4: 8 back-to-back requests, tags 0..7, res_ready=1 -> 8 consecutive res_valid cycles with tags 0..7 in order.
REQ-043 Scenario 5: rst pulsed 1 cycle after 2 accepts -> no res_valid afterwards, proto_err=0, req_ready=1 after rst falls.
REQ-044 Scenario 6: sq_enable_out forced to 1 with no accept -> proto_err=1 on the next edge; queue count unchanged.
